// File: rtl/imem_loader.sv
// Serial program loader: receives a framed program image over a byte
// stream, writes it into instruction memory, and stalls the CPU while
// loading. A good frame ends with a one-cycle CPU restart.
module imem_loader #(
  parameter int         INST_W         = 16,
  parameter int         I_ADDR_W       = 12,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                imem_we,
  output logic [I_ADDR_W-1:0] imem_waddr,
  output logic [INST_W-1:0]   imem_wdata,
  output logic                cpu_hold,
  output logic                cpu_restart,
  output logic                load_done,
  output logic                load_error,
  output logic [1:0]          error_code
);

  localparam int INST_W_BYTES = INST_W / 8;
  localparam int MAX_WORDS    = (2 ** I_ADDR_W) / INST_W_BYTES;
  localparam logic [7:0] LAST_BYTE = 8'(INST_W_BYTES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         idx_q, idx_d;
  logic [7:0]          bcnt_q, bcnt_d;
  logic [INST_W-1:0]   word_q, word_d;
  logic [7:0]          chk_q, chk_d;
  logic [31:0]         tmo_q, tmo_d;
  logic                we_q, we_d;
  logic [I_ADDR_W-1:0] waddr_q, waddr_d;
  logic [INST_W-1:0]   wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                restart_q, restart_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;

  logic                accept;
  logic                in_frame;
  logic [15:0]         n_words;
  logic [31:0]         addr_full;

  // The loader never back-pressures, so every valid byte is a transfer.
  assign rx_ready = 1'b1;
  assign accept   = rx_valid;
  assign in_frame = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CHECK);

  // Next-state and output computation for the frame parser.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    chk_d     = chk_q;
    tmo_d     = tmo_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    restart_d = 1'b0;
    done_d    = done_q;
    err_d     = err_q;
    code_d    = code_q;
    n_words   = {rx_data, len_q[7:0]};
    addr_full = 32'(idx_q) * 32'(INST_W_BYTES);

    if (in_frame) begin
      tmo_d = accept ? '0 : tmo_q + 32'd1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_d = S_LEN_LO;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = 2'd0;
          chk_d   = '0;
          tmo_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          chk_d      = chk_q ^ rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = n_words;
          chk_d = chk_q ^ rx_data;
          if (32'(n_words) > 32'(MAX_WORDS)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            code_d  = 2'd2;
          end else if (n_words == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            bcnt_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d = chk_q ^ rx_data;
          for (int unsigned b = 0; b < INST_W_BYTES; b++) begin
            if (bcnt_q == 8'(b)) word_d[b*8 +: 8] = rx_data;
          end
          if (bcnt_q == LAST_BYTE) begin
            we_d    = 1'b1;
            waddr_d = addr_full[I_ADDR_W-1:0];
            wdata_d = word_d;
            bcnt_d  = '0;
            idx_d   = idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) state_d = S_CHECK;
          end else begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (rx_data == chk_q) begin
            state_d   = S_DONE;
            hold_d    = 1'b0;
            restart_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            code_d  = 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout only fires on an idle cycle inside a frame; a byte arriving
    // on the same cycle wins and clears the counter instead.
    if (in_frame && !accept && (tmo_q + 32'd1 == 32'(TIMEOUT_CYCLES))) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
      code_d  = 2'd3;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      word_q    <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      hold_q    <= 1'b0;
      restart_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      word_q    <= word_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      restart_q <= restart_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign imem_we     = we_q;
  assign imem_waddr  = waddr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_hold    = hold_q;
  assign cpu_restart = restart_q;
  assign load_done   = done_q;
  assign load_error  = err_q;
  assign error_code  = code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven byte by byte and the
// outputs are checked against hand-computed values.
module tb_imem_loader;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [11:0] imem_waddr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        cpu_restart;
  logic        load_done;
  logic        load_error;
  logic [1:0]  error_code;

  int passed = 0;
  int total  = 0;

  logic [11:0] wa[$];
  logic [15:0] wd[$];
  int          rs_n = 0;

  imem_loader #(
    .INST_W        (16),
    .I_ADDR_W      (12),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .cpu_restart(cpu_restart),
    .load_done  (load_done),
    .load_error (load_error),
    .error_code (error_code)
  );

  always #5 clk = ~clk;

  // Log every memory write and restart pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_waddr);
      wd.push_back(imem_wdata);
    end
    if (cpu_restart) rs_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},   32'(rx_ready),    32'd1);
    check({tag, "_we"},      32'(imem_we),     32'd0);
    check({tag, "_waddr"},   32'(imem_waddr),  32'd0);
    check({tag, "_wdata"},   32'(imem_wdata),  32'd0);
    check({tag, "_hold"},    32'(cpu_hold),    32'd0);
    check({tag, "_restart"}, 32'(cpu_restart), 32'd0);
    check({tag, "_done"},    32'(load_done),   32'd0);
    check({tag, "_err"},     32'(load_error),  32'd0);
    check({tag, "_code"},    32'(error_code),  32'd0);
  endtask

  int wb, rb;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    step();
    step();
    check_reset_vals("rst");
    reset = 1'b0;
    step();

    // Frame 1: two words; checksum = 02^00^34^12^78^56 = 0A.
    wb = wa.size(); rb = rs_n;
    send(8'hA5);
    check("t1_hold_after_sync", 32'(cpu_hold), 32'd1);
    send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    check("t1_hold_before_chk", 32'(cpu_hold), 32'd1);
    send(8'h0A);
    check("t1_restart", 32'(cpu_restart), 32'd1);
    check("t1_done",    32'(load_done),   32'd1);
    check("t1_hold",    32'(cpu_hold),    32'd0);
    check("t1_err",     32'(load_error),  32'd0);
    step();
    check("t1_restart_pulse", 32'(cpu_restart), 32'd0);
    check("t1_nwrites", 32'(wa.size() - wb), 32'd2);
    if (wa.size() - wb == 2) begin
      check("t1_a0", 32'(wa[wb]),   32'h000);
      check("t1_d0", 32'(wd[wb]),   32'h1234);
      check("t1_a1", 32'(wa[wb+1]), 32'h002);
      check("t1_d1", 32'(wd[wb+1]), 32'h5678);
    end
    check("t1_nrestart", 32'(rs_n - rb), 32'd1);

    // Frame 2: same payload with a bad checksum.
    wb = wa.size(); rb = rs_n;
    send(8'hA5);
    check("t2_done_cleared", 32'(load_done), 32'd0);
    send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    send(8'h00);
    step();
    check("t2_err",       32'(load_error), 32'd1);
    check("t2_code",      32'(error_code), 32'd1);
    check("t2_hold",      32'(cpu_hold),   32'd1);
    check("t2_done",      32'(load_done),  32'd0);
    check("t2_nwrites",   32'(wa.size() - wb), 32'd2);
    check("t2_nrestart",  32'(rs_n - rb), 32'd0);

    // Frame 3: empty image.
    wb = wa.size(); rb = rs_n;
    send(8'hA5);
    check("t3_err_cleared", 32'(load_error), 32'd0);
    send(8'h00); send(8'h00); send(8'h00);
    step(); step();
    check("t3_done",     32'(load_done), 32'd1);
    check("t3_hold",     32'(cpu_hold),  32'd0);
    check("t3_nwrites",  32'(wa.size() - wb), 32'd0);
    check("t3_nrestart", 32'(rs_n - rb), 32'd1);

    // Frame 4: N = 2049 exceeds the 2048-word memory.
    wb = wa.size();
    send(8'hA5); send(8'h01); send(8'h08);
    check("t4_err",     32'(load_error), 32'd1);
    check("t4_code",    32'(error_code), 32'd2);
    check("t4_hold",    32'(cpu_hold),   32'd1);
    check("t4_nwrites", 32'(wa.size() - wb), 32'd0);

    // Frame 5: stall after the first payload byte until timeout.
    send(8'hA5); send(8'h01); send(8'h00); send(8'h34);
    repeat (TMO - 1) step();
    check("t5_no_err_early", 32'(load_error), 32'd0);
    step();
    check("t5_err",  32'(load_error), 32'd1);
    check("t5_code", 32'(error_code), 32'd3);
    check("t5_hold", 32'(cpu_hold),   32'd1);
    // Recovery frame with a SYNC byte inside the payload: 01^00^A5^5A = FE.
    wb = wa.size(); rb = rs_n;
    send(8'hA5); send(8'h01); send(8'h00); send(8'hA5); send(8'h5A); send(8'hFE);
    step();
    check("t5r_done",     32'(load_done), 32'd1);
    check("t5r_err",      32'(load_error), 32'd0);
    check("t5r_nwrites",  32'(wa.size() - wb), 32'd1);
    if (wa.size() - wb == 1) begin
      check("t5r_a0", 32'(wa[wb]), 32'h000);
      check("t5r_d0", 32'(wd[wb]), 32'h5AA5);
    end
    check("t5r_nrestart", 32'(rs_n - rb), 32'd1);

    // Noise while DONE is ignored.
    wb = wa.size();
    send(8'h00); send(8'hFF); send(8'h11);
    step();
    check("t6_noise_done", 32'(load_done), 32'd1);
    check("t6_noise_hold", 32'(cpu_hold),  32'd0);
    check("t6_noise_nw",   32'(wa.size() - wb), 32'd0);
    // Frame 1 again, then reset after the first word is written.
    send(8'hA5); send(8'h02); send(8'h00); send(8'h34); send(8'h12);
    check("t6_we_mid",   32'(imem_we),    32'd1);
    check("t6_wd_mid",   32'(imem_wdata), 32'h1234);
    check("t6_hold_mid", 32'(cpu_hold),   32'd1);
    send(8'h78);
    reset = 1'b1;
    step();
    check_reset_vals("t6_rst");
    reset = 1'b0;
    step();
    // Loader is back in IDLE: the tail of the old frame must be ignored.
    send(8'h56); send(8'h0A);
    step();
    check("t6_post_done", 32'(load_done), 32'd0);
    check("t6_post_hold", 32'(cpu_hold),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
